dds_multimode_generator: RTL and testbench
==========================================

Name: dds_multimode_generator

Overview:
- Parametrised successor to the fixed 10-bit sine generator.
- Contains a programmable phase accumulator with frequency tuning word (FTW) and phase offset word (POW).
- Uses a quarter-wave sine ROM and selectable waveform modes (sine, cosine, triangle, square, sawtooth).
- Runtime reconfiguration uses a valid/ready handshake, applied either immediately or phase-synchronously at accumulator wrap.
- Feeds the DAC interface; replaces the fixed accumulator/converter pair at top level.

Parameters:
- ACC_WIDTH, 24, accumulator and FTW width.
- PHASE_WIDTH, 10, truncated phase width (P); ROM depth is 2^(P-2); must be >= 4.
- AMP_WIDTH, 10, output amplitude width (A), offset-binary; ROM word width is A-1.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  accumulator advances on enabled cycles.
- cfg_valid  in  1  config update request.
- cfg_ready  out  1  high when no update is pending.
- cfg_ftw  in  ACC_WIDTH  frequency tuning word.
- cfg_pow  in  PHASE_WIDTH  phase offset word.
- cfg_mode  in  3  waveform select.
- cfg_sync  in  1  0 = apply immediately; 1 = apply at next wrap.
- cfg_clr  in  1  zero the accumulator when the config is applied.
- phase  out  PHASE_WIDTH  acc[ACC_WIDTH-1 -: P] + pow (mod 2^P), registered with acc.
- wrap  out  1  one-cycle pulse on accumulator carry-out.
- data_out  out  AMP_WIDTH  waveform sample.
- data_valid  out  1  data_out corresponds to an enabled cycle.

Behaviour:
- Reset values (reset low, asynchronous): acc=0, ftw=0, pow=0, mode=0, phase=0, wrap=0, data_out=2^(A-1), data_valid=0, cfg_ready=1, pending=0; pipeline valid bits cleared.
- Accumulator: on an enabled edge, acc <= acc + ftw (mod 2^ACC_WIDTH) and wrap <= carry-out. When enable is low, acc holds and wrap=0.
- Pipeline: three register stages after acc, free-running. data_out/data_valid at edge k+3 reflect the acc/phase value registered at edge k. data_valid = enable delayed 3 cycles.
  - S1: register phase p and mode, and compute quadrant q=p[P-1:P-2], index i=p[P-3:0], addr = q[0] ? ~i : i.
  - S2: registered ROM read.
  - S3: mode mux.
- ROM content: rom[i] = round((2^(A-1)-1) * sin(pi/2 * (i+0.5) / 2^(P-2))).
- Modes, with mid = 2^(A-1):
  - 0 sine: q[1]=0 -> mid+rom; q[1]=1 -> mid-1-rom.
  - 1 cosine: sine of p + 2^(P-2).
  - 2 triangle: P-bit value q[1]==0 ? {p[P-2:0],0} : ~{p[P-2:0],0}, MSB-aligned to A bits (truncate or zero-pad LSBs).
  - 3 square: p[P-1]==0 ? 2^A-1 : 0.
  - 4 sawtooth: p MSB-aligned to A bits.
  - 5-7 reserved: output mid.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready; all cfg_* fields are captured into a shadow register.
  - cfg_sync=0: applied on the next edge, cfg_ready stays 1.
  - cfg_sync=1: pending=1 and cfg_ready=0 until an enabled edge produces carry-out. On that edge the new ftw/pow/mode load (the accumulator sum uses the old ftw), and cfg_ready returns to 1 on the following cycle.
  - cfg_valid while cfg_ready=0 is ignored; there is no queueing.
  - cfg_clr applied: acc <= 0 on the apply edge, overriding the accumulate; wrap=0 on that edge.
  - Reset during a pending update discards it.
- Mode/pow changes propagate through the pipeline in order; no glitch filtering.

Optional Feature:
- DDS_PHASE_DITHER_EN defined: 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 on reset, steps each enabled cycle. Its low (ACC_WIDTH-P) bits, zero-extended, are added to acc before truncation to form phase; acc itself is unaffected.
- Undefined: plain truncation, and no LFSR logic is present.

Decomposition:
- Package dds_pkg: mode encodings (MODE_SINE=0, MODE_COS=1, MODE_TRI=2, MODE_SQR=3, MODE_SAW=4), LFSR seed/taps, and a midscale function.
- Sub-module quarter_sine_rom (params PHASE_WIDTH, AMP_WIDTH; registered output; contents generated at elaboration).

Test Plan (macro undefined, defaults):
1. Reset low then high, enable=0 -> data_out=512, data_valid=0, cfg_ready=1, phase=0; reset release mid-clock-high causes no glitch.
2. Immediate config ftw=16384, mode 0, enable=1 -> phase increments by 1 per cycle; data_out max 1023 at p=255, min 0 at p=767; wrap pulses every 1024 cycles; data_valid rises 3 cycles after enable.
3. Mode 3, ftw=2^23 -> phase alternates 0,512; data_out alternates 1023,0 after 3-cycle latency.
4. At phase 100, send cfg_sync=1, ftw=32768 -> cfg_ready=0 until wrap; a second cfg_valid is ignored; the step becomes 2 starting after the wrap edge; cfg_ready=1 the next cycle.
5. Mode 0 with pow=256 matches mode 1 with pow=0, sample by sample; mode 6 -> 512 constant.
6. Assert reset mid-run with no clock edge -> all outputs take reset values immediately; the pending sync update is lost.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared definitions for the multimode DDS: waveform mode encodings,
// dither LFSR constants and the offset-binary midscale helper.
package dds_pkg;

    typedef enum logic [2:0] {
        MODE_SINE = 3'd0,
        MODE_COS  = 3'd1,
        MODE_TRI  = 3'd2,
        MODE_SQR  = 3'd3,
        MODE_SAW  = 3'd4
    } dds_mode_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [31:0] midscale(input int unsigned amp_width);
        return 32'd1 << (amp_width - 1);
    endfunction

endpackage

// File: rtl/dds_multimode_generator_rom.sv
// Quarter-wave sine table with a registered read port; contents are
// computed at elaboration from the phase and amplitude widths.
module quarter_sine_rom #(
    parameter int unsigned PHASE_WIDTH = 10,
    parameter int unsigned AMP_WIDTH   = 10
) (
    input  logic                   clock_i,
    input  logic                   reset_ni,
    input  logic [PHASE_WIDTH-3:0] addr_i,
    output logic [AMP_WIDTH-2:0]   data_o
);

    localparam int DEPTH = 2 ** (PHASE_WIDTH - 2);
    localparam int W     = AMP_WIDTH - 1;

    function automatic logic [W-1:0] rom_entry(input int idx);
        real amp;
        real x;
        amp = real'((32'd1 << W) - 32'd1);
        x   = amp * $sin(3.14159265358979323846 / 2.0 * (real'(idx) + 0.5) / real'(DEPTH));
        return W'($rtoi(x + 0.5));
    endfunction

    logic [W-1:0] table_w [DEPTH];
    logic [W-1:0] data_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        assign table_w[g] = rom_entry(g);
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) data_q <= '0;
        else           data_q <= table_w[addr_i];
    end

    assign data_o = data_q;

endmodule

// File: rtl/dds_multimode_generator.sv
// Multimode DDS: phase accumulator with handshaked FTW/POW/mode updates and a
// 3-stage waveform pipeline. Define DDS_PHASE_DITHER_EN to add LFSR phase dither.
module dds_multimode_generator
    import dds_pkg::*;
#(
    parameter int unsigned ACC_WIDTH   = 24,
    parameter int unsigned PHASE_WIDTH = 10,
    parameter int unsigned AMP_WIDTH   = 10
) (
    input  logic                   clock_i,
    input  logic                   reset_ni,
    input  logic                   enable_i,
    input  logic                   cfg_valid_i,
    output logic                   cfg_ready_o,
    input  logic [ACC_WIDTH-1:0]   cfg_ftw_i,
    input  logic [PHASE_WIDTH-1:0] cfg_pow_i,
    input  logic [2:0]             cfg_mode_i,
    input  logic                   cfg_sync_i,
    input  logic                   cfg_clr_i,
    output logic [PHASE_WIDTH-1:0] phase_o,
    output logic                   wrap_o,
    output logic [AMP_WIDTH-1:0]   data_out_o,
    output logic                   data_valid_o
);

    localparam int unsigned P = PHASE_WIDTH;
    localparam int unsigned A = AMP_WIDTH;
    localparam logic [A-1:0] MID     = A'(midscale(A));
    localparam logic [A-1:0] MID_M1  = A'(midscale(A) - 32'd1);
    localparam logic [P-1:0] QUARTER = {2'b01, {(P-2){1'b0}}};

    logic [ACC_WIDTH-1:0] acc_q, acc_d, ftw_q, ftw_d, sh_ftw_q, sh_ftw_d, sum;
    logic [P-1:0]         pow_q, pow_d, sh_pow_q, sh_pow_d, phase_q, phase_d;
    logic [2:0]           mode_q, mode_d, sh_mode_q, sh_mode_d;
    logic                 wrap_q, wrap_d, pend_q, pend_d, sh_clr_q, sh_clr_d;
    logic                 carry, en0_q;

    assign cfg_ready_o = ~pend_q;

    always_comb begin
        {carry, sum} = {1'b0, acc_q} + {1'b0, ftw_q};
        acc_d     = enable_i ? sum : acc_q;
        wrap_d    = enable_i & carry;
        ftw_d     = ftw_q;
        pow_d     = pow_q;
        mode_d    = mode_q;
        pend_d    = pend_q;
        sh_ftw_d  = sh_ftw_q;
        sh_pow_d  = sh_pow_q;
        sh_mode_d = sh_mode_q;
        sh_clr_d  = sh_clr_q;
        if (cfg_valid_i && cfg_ready_o) begin
            sh_ftw_d  = cfg_ftw_i;
            sh_pow_d  = cfg_pow_i;
            sh_mode_d = cfg_mode_i;
            sh_clr_d  = cfg_clr_i;
            if (cfg_sync_i) begin
                pend_d = 1'b1;
            end else begin
                ftw_d  = cfg_ftw_i;
                pow_d  = cfg_pow_i;
                mode_d = cfg_mode_i;
                if (cfg_clr_i) begin
                    acc_d  = '0;
                    wrap_d = 1'b0;
                end
            end
        end else if (pend_q && wrap_d) begin
            // Sum above already used the old FTW; new settings take effect from here on
            ftw_d  = sh_ftw_q;
            pow_d  = sh_pow_q;
            mode_d = sh_mode_q;
            pend_d = 1'b0;
            if (sh_clr_q) begin
                acc_d  = '0;
                wrap_d = 1'b0;
            end
        end
    end

`ifdef DDS_PHASE_DITHER_EN
    logic [15:0]          lfsr_q, lfsr_d;
    logic [ACC_WIDTH-1:0] dith, acc_dith;

    always_comb begin
        dith = '0;
        for (int unsigned b = 0; b < 16; b++) begin
            if (b < ACC_WIDTH - P && b < ACC_WIDTH) dith[b] = lfsr_q[b];
        end
        acc_dith = acc_d + dith;
        phase_d  = acc_dith[ACC_WIDTH-1 -: P] + pow_d;
        lfsr_d   = enable_i ? {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)} : lfsr_q;
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) lfsr_q <= LFSR_SEED;
        else           lfsr_q <= lfsr_d;
    end
`else
    always_comb begin
        phase_d = acc_d[ACC_WIDTH-1 -: P] + pow_d;
    end
`endif

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            acc_q     <= '0;
            ftw_q     <= '0;
            pow_q     <= '0;
            mode_q    <= '0;
            phase_q   <= '0;
            wrap_q    <= 1'b0;
            pend_q    <= 1'b0;
            sh_ftw_q  <= '0;
            sh_pow_q  <= '0;
            sh_mode_q <= '0;
            sh_clr_q  <= 1'b0;
            en0_q     <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            ftw_q     <= ftw_d;
            pow_q     <= pow_d;
            mode_q    <= mode_d;
            phase_q   <= phase_d;
            wrap_q    <= wrap_d;
            pend_q    <= pend_d;
            sh_ftw_q  <= sh_ftw_d;
            sh_pow_q  <= sh_pow_d;
            sh_mode_q <= sh_mode_d;
            sh_clr_q  <= sh_clr_d;
            en0_q     <= enable_i;
        end
    end

    assign phase_o = phase_q;
    assign wrap_o  = wrap_q;

    logic [P-1:0]   p1_q, p2_q, pe;
    logic [2:0]     mode1_q, mode2_q;
    logic           v1_q, v2_q, v3_q, neg2_q;
    logic [P-3:0]   addr;
    logic [A-2:0]   rom_data;
    logic [A-1:0]   rom_ext, wave, data_q;
    logic [P-1:0]   tri_p;
    logic [P+A-1:0] tri_w, saw_w;

    // Cosine reuses the sine path with the phase advanced by a quarter turn
    always_comb begin
        pe   = p1_q + ((mode1_q == MODE_COS) ? QUARTER : '0);
        addr = pe[P-2] ? ~pe[P-3:0] : pe[P-3:0];
    end

    quarter_sine_rom #(
        .PHASE_WIDTH(P),
        .AMP_WIDTH  (A)
    ) u_rom (
        .clock_i (clock_i),
        .reset_ni(reset_ni),
        .addr_i  (addr),
        .data_o  (rom_data)
    );

    always_comb begin
        rom_ext = {1'b0, rom_data};
        tri_p   = p2_q[P-1] ? ~{p2_q[P-2:0], 1'b0} : {p2_q[P-2:0], 1'b0};
        tri_w   = {tri_p, {A{1'b0}}};
        saw_w   = {p2_q, {A{1'b0}}};
        case (mode2_q)
            MODE_SINE, MODE_COS: wave = neg2_q ? (MID_M1 - rom_ext) : (MID + rom_ext);
            MODE_TRI:            wave = tri_w[P+A-1 -: A];
            MODE_SQR:            wave = p2_q[P-1] ? '0 : '1;
            MODE_SAW:            wave = saw_w[P+A-1 -: A];
            default:             wave = MID;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            p1_q    <= '0;
            mode1_q <= '0;
            v1_q    <= 1'b0;
            p2_q    <= '0;
            mode2_q <= '0;
            neg2_q  <= 1'b0;
            v2_q    <= 1'b0;
            data_q  <= MID;
            v3_q    <= 1'b0;
        end else begin
            p1_q    <= phase_q;
            mode1_q <= mode_q;
            v1_q    <= en0_q;
            p2_q    <= p1_q;
            mode2_q <= mode1_q;
            neg2_q  <= pe[P-1];
            v2_q    <= v1_q;
            data_q  <= wave;
            v3_q    <= v2_q;
        end
    end

    assign data_out_o   = data_q;
    assign data_valid_o = v3_q;

endmodule

// File: tb/tb_dds_multimode_generator.sv
// Self-checking bench for dds_multimode_generator (default parameters, no dither).
module tb_dds_multimode_generator;

    localparam int unsigned AW = 24;
    localparam int unsigned PW = 10;
    localparam int unsigned DW = 10;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          en = 1'b0, cv = 1'b0, csync = 1'b0, cclr = 1'b0;
    logic [AW-1:0] cftw = '0;
    logic [PW-1:0] cpow = '0;
    logic [2:0]    cmode = '0;
    logic          cready, wrap, dvalid;
    logic [PW-1:0] phase;
    logic [DW-1:0] dout;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    dds_multimode_generator #(
        .ACC_WIDTH  (AW),
        .PHASE_WIDTH(PW),
        .AMP_WIDTH  (DW)
    ) dut (
        .clock_i     (clock),
        .reset_ni    (reset_n),
        .enable_i    (en),
        .cfg_valid_i (cv),
        .cfg_ready_o (cready),
        .cfg_ftw_i   (cftw),
        .cfg_pow_i   (cpow),
        .cfg_mode_i  (cmode),
        .cfg_sync_i  (csync),
        .cfg_clr_i   (cclr),
        .phase_o     (phase),
        .wrap_o      (wrap),
        .data_out_o  (dout),
        .data_valid_o(dvalid)
    );

    logic [AW-1:0] m_acc, m_ftw, s_ftw;
    logic [PW-1:0] m_pow, s_pow, m_phase;
    logic [2:0]    m_mode, s_mode;
    logic          m_pend, s_clr, m_wrap;

    typedef struct {
        logic v;
        int   d;
    } exp_t;
    exp_t sb[$];

    typedef struct packed {
        int pow;
        int mode;
        int exp;
    } vec_t;
    vec_t vecs [0:17];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sine_ref(input int p);
        real s;
        s = $sin(2.0 * 3.14159265358979323846 * (real'(p) + 0.5) / 1024.0);
        if (s >= 0.0) return 512 + $rtoi(511.0 * s + 0.5);
        else          return 511 - $rtoi(-511.0 * s + 0.5);
    endfunction

    function automatic int wave(input int p, input int mode);
        case (mode)
            0:       return sine_ref(p);
            1:       return sine_ref((p + 256) % 1024);
            2:       return (p < 512) ? 2 * (p % 512) : 1023 - 2 * (p % 512);
            3:       return (p < 512) ? 1023 : 0;
            4:       return p;
            default: return 512;
        endcase
    endfunction

    task automatic model_reset();
        exp_t e;
        m_acc = '0; m_ftw = '0; s_ftw = '0;
        m_pow = '0; s_pow = '0; m_phase = '0;
        m_mode = '0; s_mode = '0;
        m_pend = 1'b0; s_clr = 1'b0; m_wrap = 1'b0;
        sb.delete();
        e.v = 1'b0;
        e.d = 512;
        repeat (3) sb.push_back(e);
    endtask

    task automatic tick();
        logic [AW:0]   sum;
        logic          carry, nwrap, rdy;
        logic [AW-1:0] nacc;
        exp_t          e;
        @(posedge clock);
        rdy   = !m_pend;
        sum   = {1'b0, m_acc} + {1'b0, m_ftw};
        carry = en && sum[AW];
        nacc  = en ? sum[AW-1:0] : m_acc;
        nwrap = carry;
        if (cv && rdy) begin
            s_ftw = cftw; s_pow = cpow; s_mode = cmode; s_clr = cclr;
            if (csync) begin
                m_pend = 1'b1;
            end else begin
                m_ftw = cftw; m_pow = cpow; m_mode = cmode;
                if (cclr) begin nacc = '0; nwrap = 1'b0; end
            end
        end else if (m_pend && carry) begin
            m_ftw = s_ftw; m_pow = s_pow; m_mode = s_mode; m_pend = 1'b0;
            if (s_clr) begin nacc = '0; nwrap = 1'b0; end
        end
        m_acc   = nacc;
        m_wrap  = nwrap;
        m_phase = m_acc[AW-1 -: PW] + m_pow;
        e.v = en;
        e.d = wave(int'(m_phase), int'(m_mode));
        sb.push_back(e);
        #1;
        check("phase", int'(phase), int'(m_phase));
        check("wrap", int'(wrap), int'(m_wrap));
        check("cfg_ready", int'(cready), int'(!m_pend));
        e = sb.pop_front();
        check("data_valid", int'(dvalid), int'(e.v));
        if (e.v) check("data_out", int'(dout), e.d);
    endtask

    task automatic cfg(input logic [AW-1:0] ftw, input int pow, input int mode,
                       input logic sync, input logic clr);
        cftw = ftw; cpow = PW'(pow); cmode = 3'(mode); csync = sync; cclr = clr;
        cv = 1'b1;
        tick();
        cv = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_out"}, int'(dout), 512);
        check({tag, "_data_valid"}, int'(dvalid), 0);
        check({tag, "_cfg_ready"}, int'(cready), 1);
        check({tag, "_phase"}, int'(phase), 0);
        check({tag, "_wrap"}, int'(wrap), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int last_wrap;
        int prev;
        int found;
        int a [64];
        int b [64];

        vecs = '{
            '{255, 0, 1023}, '{767, 0, 0},    '{0, 0, 514},    '{512, 0, 509},
            '{0, 1, 1023},   '{512, 1, 0},    '{0, 2, 0},      '{256, 2, 512},
            '{511, 2, 1022}, '{512, 2, 1023}, '{1023, 2, 1},   '{0, 3, 1023},
            '{511, 3, 1023}, '{512, 3, 0},    '{700, 4, 700},  '{1023, 4, 1023},
            '{300, 5, 512},  '{300, 7, 512}
        };

        // Reset, then release while the clock is high
        model_reset();
        #16;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        #1;
        check_reset_outputs("release");
        repeat (3) tick();

        // Sine sweep at one phase step per cycle
        en = 1'b1;
        cfg(24'd16384, 0, 0, 1'b0, 1'b1);
        last_wrap = -1;
        for (int i = 0; i < 2100; i++) begin
            tick();
            if (wrap) begin
                if (last_wrap >= 0) check("wrap_period", i - last_wrap, 1024);
                last_wrap = i;
            end
        end

        // Square at half-turn step
        cfg(24'h800000, 0, 3, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            prev = int'(phase);
            tick();
            check("sqr_phase_alt", int'(phase) ^ prev, 512);
        end

        // Static-phase table
        for (int i = 0; i < 18; i++) begin
            cfg('0, vecs[i].pow, vecs[i].mode, 1'b0, 1'b1);
            repeat (3) tick();
            check("table_phase", int'(phase), vecs[i].pow);
            check("table_data", int'(dout), vecs[i].exp);
        end

        // Phase-synchronous update
        cfg(24'd16384, 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 200 && phase != 10'd100; i++) tick();
        check("reach_p100", int'(phase), 100);
        cfg(24'd32768, 0, 0, 1'b1, 1'b0);
        check("sync_ready_low", int'(cready), 0);
        cfg(24'd1, 0, 4, 1'b0, 1'b1);
        check("ignored_ready_low", int'(cready), 0);
        found = 0;
        for (int i = 0; i < 1100 && found == 0; i++) begin
            prev = int'(phase);
            tick();
            if (wrap) found = 1;
            else check("pre_wrap_step", (int'(phase) - prev + 1024) % 1024, 1);
        end
        check("sync_wrap_seen", found, 1);
        check("ready_after_wrap", int'(cready), 1);
        for (int i = 0; i < 4; i++) begin
            prev = int'(phase);
            tick();
            check("post_wrap_step", (int'(phase) - prev + 1024) % 1024, 2);
        end

        // Sine with quarter offset equals cosine
        cfg(24'd262144, 256, 0, 1'b0, 1'b1);
        repeat (2) tick();
        for (int k = 0; k < 64; k++) begin tick(); a[k] = int'(dout); end
        cfg(24'd262144, 0, 1, 1'b0, 1'b1);
        repeat (2) tick();
        for (int k = 0; k < 64; k++) begin tick(); b[k] = int'(dout); end
        for (int k = 0; k < 64; k++) check("cos_vs_sin", b[k], a[k]);
        cfg(24'd16384, 0, 6, 1'b0, 1'b1);
        repeat (4) tick();
        check("reserved_mid", int'(dout), 512);

        // Asynchronous reset with an update pending
        cfg(24'd16384, 0, 0, 1'b0, 1'b1);
        repeat (50) tick();
        cfg(24'd32768, 0, 2, 1'b1, 1'b0);
        repeat (5) tick();
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        #2;
        reset_n = 1'b1;
        repeat (1100) tick();
        check("pending_lost_ready", int'(cready), 1);
        check("pending_lost_phase", int'(phase), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
